// File: rtl/pc_trace_buffer_pkg.sv
// Shared definitions for the PC trace recorder: FSM encodings and the packed entry width.
package pc_trace_buffer_pkg;

  typedef enum logic [1:0] {
    TRC_IDLE  = 2'd0,
    TRC_ARMED = 2'd1,
    TRC_POST  = 2'd2,
    TRC_DONE  = 2'd3
  } trc_state_t;

  // One stored entry is {pc, result, timestamp}.
  function automatic int entry_width(input int data_w, input int ts_w);
    return 2 * data_w + ts_w;
  endfunction

endpackage

// File: rtl/pc_trace_buffer_trace_ram.sv
// Simple dual-port trace storage: one synchronous write port, one registered read port.
module trace_ram #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the output register is reset; it holds its value between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pc_trace_buffer.sv
// Circular PC/Result trace recorder with timestamps and pre/post-trigger windowing.
module pc_trace_buffer
  import pc_trace_buffer_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int POST_TRIG   = 32,
  parameter int TS_W        = 16,
  parameter bit CHANGE_ONLY = 1'b0,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Ena,
  input  logic              arm,
  input  logic              trig,
  input  logic [DATA_W-1:0] PCValue,
  input  logic [DATA_W-1:0] Result,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_idx,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_pc,
  output logic [DATA_W-1:0] rd_result,
  output logic [TS_W-1:0]   rd_ts,
  output logic [1:0]        state,
  output logic [AW:0]       entries,
  output logic              overflow
);

  localparam int           EW        = entry_width(DATA_W, TS_W);
  localparam logic [AW:0]  FULL      = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);

  trc_state_t        st;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     post_cnt;
  logic [TS_W-1:0]   ts;
  logic [DATA_W-1:0] last_pc;
  logic              capturing;
  logic              sample;
  logic              rd_go;
  logic [AW-1:0]     rd_addr;
  logic [EW-1:0]     rd_data;

  assign capturing = Ena && (st == TRC_ARMED || st == TRC_POST);
  // entries==0 marks the first write after arm, which always qualifies.
  assign sample    = capturing && !arm &&
                     (!CHANGE_ONLY || entries == '0 || PCValue != last_pc);
  assign rd_go     = rd_en && st == TRC_DONE && ({1'b0, rd_idx} < entries);
  // Logical index 0 is the oldest entry; entries mod DEPTH is 0 when full.
  assign rd_addr   = wr_ptr - entries[AW-1:0] + rd_idx;
  assign state     = st;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      st       <= TRC_IDLE;
      entries  <= '0;
      overflow <= 1'b0;
      ts       <= '0;
      wr_ptr   <= '0;
      post_cnt <= '0;
      last_pc  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_go;
      if (arm) begin
        st       <= TRC_ARMED;
        entries  <= '0;
        overflow <= 1'b0;
        ts       <= '0;
        wr_ptr   <= '0;
        post_cnt <= '0;
      end else begin
        if (capturing) ts <= ts + 1'b1;
        if (sample) begin
          wr_ptr  <= wr_ptr + 1'b1;
          last_pc <= PCValue;
          if (entries == FULL) overflow <= 1'b1;
          else                 entries  <= entries + 1'b1;
          case (st)
            TRC_ARMED: begin
              if (trig) begin
                post_cnt <= POST_INIT;
                st       <= (POST_TRIG == 0) ? TRC_DONE : TRC_POST;
              end
            end
            TRC_POST: begin
              post_cnt <= post_cnt - 1'b1;
              if (post_cnt == AW'(1)) st <= TRC_DONE;
            end
            default: ;
          endcase
        end
      end
    end
  end

  trace_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (Clk),
    .rst     (Reset),
    .wr_en   (sample),
    .wr_addr (wr_ptr),
    .wr_data ({PCValue, Result, ts}),
    .rd_en   (rd_go),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign rd_pc     = rd_data[EW-1 -: DATA_W];
  assign rd_result = rd_data[TS_W +: DATA_W];
  assign rd_ts     = rd_data[TS_W-1:0];

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Directed bench for pc_trace_buffer: table-driven capture plus hand sequences for corner cases.
module tb_pc_trace_buffer;

  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  localparam int TSW = 16;

  logic          Clk = 1'b0;
  logic          Reset, Ena, arm, trig, rd_en;
  logic [DW-1:0] PCValue, Result;
  logic [AW-1:0] rd_idx;

  logic          a_rd_valid, b_rd_valid, a_overflow, b_overflow;
  logic [DW-1:0] a_rd_pc, a_rd_result, b_rd_pc, b_rd_result;
  logic [TSW-1:0] a_rd_ts, b_rd_ts;
  logic [1:0]    a_state, b_state;
  logic [AW:0]   a_entries, b_entries;

  int errors = 0;
  int checks = 0;
  logic [TSW-1:0] ts0;

  always #5 Clk = ~Clk;
  assign Result = PCValue ^ 32'hA5A5_0000;

  pc_trace_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .POST_TRIG(2), .TS_W(TSW), .CHANGE_ONLY(1'b0)) dut_a (
    .Clk(Clk), .Reset(Reset), .Ena(Ena), .arm(arm), .trig(trig), .PCValue(PCValue),
    .Result(Result), .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(a_rd_valid), .rd_pc(a_rd_pc),
    .rd_result(a_rd_result), .rd_ts(a_rd_ts), .state(a_state), .entries(a_entries),
    .overflow(a_overflow));

  pc_trace_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .POST_TRIG(2), .TS_W(TSW), .CHANGE_ONLY(1'b1)) dut_b (
    .Clk(Clk), .Reset(Reset), .Ena(Ena), .arm(arm), .trig(trig), .PCValue(PCValue),
    .Result(Result), .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(b_rd_valid), .rd_pc(b_rd_pc),
    .rd_result(b_rd_result), .rd_ts(b_rd_ts), .state(b_state), .entries(b_entries),
    .overflow(b_overflow));

  typedef struct {
    logic        arm;
    logic        trig;
    logic [31:0] pc;
    logic [1:0]  st;
    logic [3:0]  ent;
    logic        ovf;
  } vec_t;

  vec_t tv[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] idx);
    rd_en = 1'b1;
    rd_idx = idx;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    // Capture with DEPTH=8, POST_TRIG=2: PC=4k, trigger at 0x28, DONE after 0x30.
    tv[0] = '{arm: 1'b1, trig: 1'b0, pc: 32'h0, st: 2'd1, ent: 4'd0, ovf: 1'b0};
    for (int k = 0; k < 13; k++) begin
      tv[k+1].arm  = 1'b0;
      tv[k+1].trig = (k == 10);
      tv[k+1].pc   = 32'(4 * k);
      tv[k+1].st   = (k < 10) ? 2'd1 : (k < 12) ? 2'd2 : 2'd3;
      tv[k+1].ent  = (k < 8) ? 4'(k + 1) : 4'd8;
      tv[k+1].ovf  = (k >= 8);
    end
    tv[14] = '{arm: 1'b0, trig: 1'b0, pc: 32'h34, st: 2'd3, ent: 4'd8, ovf: 1'b1};

    Reset = 1'b1; Ena = 1'b1; arm = 1'b0; trig = 1'b0; rd_en = 1'b0; rd_idx = '0;
    PCValue = '0;
    step(); step();
    Reset = 1'b0;
    step();
    chk("reset_state", 32'(a_state), 32'd0);
    chk("reset_entries", 32'(a_entries), 32'd0);
    chk("reset_rd_valid", 32'(a_rd_valid), 32'd0);

    // trig in IDLE is ignored
    trig = 1'b1; PCValue = 32'h40;
    step();
    chk("idle_trig_state", 32'(a_state), 32'd0);
    chk("idle_trig_entries", 32'(a_entries), 32'd0);

    // arm and trig together: arm wins, no trigger
    arm = 1'b1;
    step();
    chk("arm_trig_state", 32'(a_state), 32'd1);
    arm = 1'b0; trig = 1'b0; PCValue = 32'h44;
    step();
    chk("arm_trig_no_post", 32'(a_state), 32'd1);
    chk("arm_trig_entries", 32'(a_entries), 32'd1);

    // Reset while ARMED with 5 entries, observed without a clock edge
    for (int i = 0; i < 4; i++) begin
      PCValue = 32'h48 + 32'(4 * i);
      step();
    end
    chk("pre_reset_entries", 32'(a_entries), 32'd5);
    #2 Reset = 1'b1;
    #1;
    chk("async_reset_state", 32'(a_state), 32'd0);
    chk("async_reset_entries", 32'(a_entries), 32'd0);
    chk("async_reset_overflow", 32'(a_overflow), 32'd0);
    chk("async_reset_rd_valid", 32'(a_rd_valid), 32'd0);
    Reset = 1'b0;
    step();

    for (int i = 0; i < 15; i++) begin
      arm = tv[i].arm; trig = tv[i].trig; PCValue = tv[i].pc;
      step();
      chk($sformatf("tv%0d_state", i), 32'(a_state), 32'(tv[i].st));
      chk($sformatf("tv%0d_entries", i), 32'(a_entries), 32'(tv[i].ent));
      chk($sformatf("tv%0d_overflow", i), 32'(a_overflow), 32'(tv[i].ovf));
    end
    arm = 1'b0; trig = 1'b0;

    // Oldest entry is PC 0x14 (written at ts=5), newest is 0x30 (ts=12)
    for (int i = 0; i < 8; i++) begin
      rd(AW'(i));
      chk($sformatf("rd%0d_valid", i), 32'(a_rd_valid), 32'd1);
      chk($sformatf("rd%0d_pc", i), a_rd_pc, 32'h14 + 32'(4 * i));
      chk($sformatf("rd%0d_result", i), a_rd_result, (32'h14 + 32'(4 * i)) ^ 32'hA5A5_0000);
      chk($sformatf("rd%0d_ts", i), 32'(a_rd_ts), 32'(5 + i));
    end

    // CHANGE_ONLY: PC 0x10 held 5 cycles then 0x14 -> 2 entries, ts delta 5
    arm = 1'b1;
    step();
    arm = 1'b0; PCValue = 32'h10;
    repeat (5) step();
    chk("chg_entries_hold", 32'(b_entries), 32'd1);
    PCValue = 32'h14;
    step();
    chk("chg_entries_new", 32'(b_entries), 32'd2);
    trig = 1'b1; PCValue = 32'h18;
    step();
    trig = 1'b0; PCValue = 32'h1C;
    step();
    PCValue = 32'h20;
    step();
    chk("chg_done_state", 32'(b_state), 32'd3);
    chk("chg_done_entries", 32'(b_entries), 32'd5);
    rd(3'd0);
    chk("chg_rd0_pc", b_rd_pc, 32'h10);
    chk("chg_rd0_ts", 32'(b_rd_ts), 32'd0);
    ts0 = b_rd_ts;
    rd(3'd1);
    chk("chg_rd1_pc", b_rd_pc, 32'h14);
    chk("chg_ts_delta", 32'(b_rd_ts - ts0), 32'd5);

    // Ena low mid-ARMED: no writes, ts frozen; rd_en while ARMED gives no data
    arm = 1'b1;
    step();
    arm = 1'b0; PCValue = 32'h200;
    step();
    PCValue = 32'h204;
    step();
    Ena = 1'b0; rd_en = 1'b1; rd_idx = '0;
    for (int i = 0; i < 3; i++) begin
      PCValue = 32'h208 + 32'(4 * i);
      step();
      chk("armed_rd_valid", 32'(a_rd_valid), 32'd0);
    end
    rd_en = 1'b0;
    chk("ena_low_entries", 32'(a_entries), 32'd2);
    chk("ena_low_state", 32'(a_state), 32'd1);
    Ena = 1'b1; trig = 1'b1; PCValue = 32'h300;
    step();
    chk("ena_resume_state", 32'(a_state), 32'd2);
    chk("ena_resume_entries", 32'(a_entries), 32'd3);
    trig = 1'b0; PCValue = 32'h304;
    step();
    PCValue = 32'h308;
    step();
    chk("ena_done_state", 32'(a_state), 32'd3);
    rd(3'd2);
    chk("ena_rd2_pc", a_rd_pc, 32'h300);
    chk("ena_rd2_ts", 32'(a_rd_ts), 32'd2);
    rd(3'd1);
    chk("ena_rd1_ts", 32'(a_rd_ts), 32'd1);

    // DONE with 3 entries: out-of-range index, newest entry, hold
    arm = 1'b1;
    step();
    arm = 1'b0; trig = 1'b1; PCValue = 32'h100;
    step();
    trig = 1'b0; PCValue = 32'h104;
    step();
    PCValue = 32'h108;
    step();
    chk("d3_state", 32'(a_state), 32'd3);
    chk("d3_entries", 32'(a_entries), 32'd3);
    chk("d3_overflow", 32'(a_overflow), 32'd0);
    rd(3'd3);
    chk("d3_idx3_valid", 32'(a_rd_valid), 32'd0);
    rd(3'd2);
    chk("d3_idx2_valid", 32'(a_rd_valid), 32'd1);
    chk("d3_idx2_pc", a_rd_pc, 32'h108);
    chk("d3_idx2_result", a_rd_result, 32'h108 ^ 32'hA5A5_0000);
    chk("d3_idx2_ts", 32'(a_rd_ts), 32'd2);
    rd(3'd5);
    chk("d3_idx5_valid", 32'(a_rd_valid), 32'd0);
    chk("d3_hold_pc", a_rd_pc, 32'h108);
    step();
    chk("rd_valid_pulse", 32'(a_rd_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
